wide_add_sequencer: RTL and testbench



---
 rtl/wide_add_pkg.sv | 13 +
 rtl/carryselect_32_bit.sv | 25 ++
 rtl/wide_add_sequencer.sv | 133 +++++++++++++
 tb/tb_wide_add_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/wide_add_pkg.sv
// Shared types and constants for the wide add/subtract sequencer slice.
package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WORD_W = 32;
  localparam int REQ_N  = 2;

endpackage

// File: rtl/carryselect_32_bit.sv
// 32-bit carry-select adder built from 4-bit blocks, each precomputing both carry-in cases.
module carryselect_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [8:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_blk
    logic [4:0] s0;
    logic [4:0] s1;
    assign s0 = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]};
    assign s1 = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + 5'd1;
    assign sum[i*4 +: 4] = c[i] ? s1[3:0] : s0[3:0];
    assign c[i+1]        = c[i] ? s1[4]   : s0[4];
  end

  assign cout = c[8];

endmodule

// File: rtl/wide_add_sequencer.sv
// Sequences WORDS x 32-bit add/sub through one shared 32-bit adder, LS word first,
// with round-robin arbitration between two requesters and a valid/ready response.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [REQ_N-1:0]              req_valid,
  output logic [REQ_N-1:0]              req_ready,
  input  logic [REQ_N*WORDS*WORD_W-1:0] req_a,
  input  logic [REQ_N*WORDS*WORD_W-1:0] req_b,
  input  logic [REQ_N-1:0]              req_sub,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [WORDS*WORD_W-1:0]       rsp_data,
  output logic                          rsp_id,
  output logic                          rsp_cout,
  output logic                          rsp_ovf,
  output logic                          busy
);

  localparam int KW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OPW = WORDS * WORD_W;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  state_t            state;
  logic [WORD_W-1:0] a_reg [WORDS];
  logic [WORD_W-1:0] b_reg [WORDS];
  logic [WORD_W-1:0] res   [WORDS];
  logic [KW-1:0]     k;
  logic              carry_reg;
  logic              last_grant;

  logic              grant_any;
  logic              grant_id;
  logic [OPW-1:0]    sel_a;
  logic [OPW-1:0]    sel_b;
  logic              sel_sub;
  logic [WORD_W-1:0] add_a;
  logic [WORD_W-1:0] add_b;
  logic [WORD_W-1:0] add_sum;
  logic              add_cout;

  // On a tie the requester not served last wins; otherwise the lone requester.
  always_comb begin
    grant_any = |req_valid;
    grant_id  = (&req_valid) ? ~last_grant : req_valid[1];
    sel_a     = grant_id ? req_a[2*OPW-1:OPW] : req_a[OPW-1:0];
    sel_b     = grant_id ? req_b[2*OPW-1:OPW] : req_b[OPW-1:0];
    sel_sub   = req_sub[grant_id];
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && grant_any)
      req_ready[grant_id] = 1'b1;
  end

  assign add_a = a_reg[k];
  assign add_b = b_reg[k];

  carryselect_32_bit u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_reg),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= '0;
      carry_reg  <= 1'b0;
      last_grant <= 1'b1;
      rsp_id     <= 1'b0;
      rsp_cout   <= 1'b0;
      rsp_ovf    <= 1'b0;
      for (int unsigned w = 0; w < WORDS; w++) begin
        a_reg[w] <= '0;
        b_reg[w] <= '0;
        res[w]   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            // Subtraction is A + ~B + 1: invert B here, the +1 enters as the first carry-in.
            for (int unsigned w = 0; w < WORDS; w++) begin
              a_reg[w] <= sel_a[w*WORD_W +: WORD_W];
              b_reg[w] <= sel_b[w*WORD_W +: WORD_W] ^ {WORD_W{sel_sub}};
            end
            carry_reg  <= sel_sub;
            k          <= '0;
            last_grant <= grant_id;
            rsp_id     <= grant_id;
            state      <= RUN;
          end
        end
        RUN: begin
          res[k]    <= add_sum;
          carry_reg <= add_cout;
          if (k == K_LAST) begin
            k        <= '0;
            rsp_cout <= add_cout;
            rsp_ovf  <= (add_a[WORD_W-1] == add_b[WORD_W-1]) &&
                        (add_sum[WORD_W-1] != add_a[WORD_W-1]);
            state    <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rsp_data = '0;
    for (int unsigned w = 0; w < WORDS; w++)
      rsp_data[w*WORD_W +: WORD_W] = res[w];
  end

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer (WORDS=4): arithmetic corners, round-robin,
// backpressure and asynchronous reset in the middle of an operation.
module tb_wide_add_sequencer;

  localparam int WORDS = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [255:0] req_a;
  logic [255:0] req_b;
  logic [1:0]   req_sub;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_id;
  logic         rsp_cout;
  logic         rsp_ovf;
  logic         busy;

  int n_pass  = 0;
  int n_total = 0;

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Issue a request, check grant, latency and response fields, then complete
  // the response handshake if rsp_ready is high.
  task automatic do_op(input string tag, input logic [1:0] vld, input logic exp_g,
                       input logic [127:0] ed, input logic ec, input logic eo,
                       input logic [1:0] vld_after);
    int cnt;
    req_valid = vld;
    #1;
    cnt = 0;
    while (req_ready == 2'b00 && cnt < 20) begin
      step();
      cnt++;
    end
    chk({tag, "_grant"}, req_ready, exp_g ? 2'b10 : 2'b01);
    step();
    req_valid = vld_after;
    cnt = 0;
    while (!rsp_valid && cnt < 20) begin
      step();
      cnt++;
    end
    chk({tag, "_latency"}, cnt, 4);
    chk({tag, "_data"}, rsp_data, ed);
    chk({tag, "_id"}, rsp_id, exp_g);
    chk({tag, "_cout"}, rsp_cout, ec);
    chk({tag, "_ovf"}, rsp_ovf, eo);
    chk({tag, "_busy"}, busy, 1'b1);
    if (rsp_ready) begin
      step();
      chk({tag, "_valid_drop"}, rsp_valid, 1'b0);
      chk({tag, "_idle"}, busy, 1'b0);
    end
  endtask

  initial begin
    logic [127:0] held;
    int           seen;

    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    req_sub   = 2'b00;
    rsp_ready = 1'b1;
    #2;
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_data", rsp_data, '0);
    chk("rst_id", rsp_id, 1'b0);
    chk("rst_cout", rsp_cout, 1'b0);
    chk("rst_ovf", rsp_ovf, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", req_ready, 2'b00);
    req_valid = 2'b00;
    step();
    rst_n = 1'b1;
    step();

    // Round robin from reset: 0,1,0,1. r0: 5+3, r1: 10-4 (no borrow -> cout 1).
    req_a   = {128'd10, 128'd5};
    req_b   = {128'd4, 128'd3};
    req_sub = 2'b10;
    do_op("rr0", 2'b11, 1'b0, 128'd8, 1'b0, 1'b0, 2'b11);
    do_op("rr1", 2'b11, 1'b1, 128'd6, 1'b1, 1'b0, 2'b11);
    do_op("rr2", 2'b11, 1'b0, 128'd8, 1'b0, 1'b0, 2'b11);
    do_op("rr3", 2'b11, 1'b1, 128'd6, 1'b1, 1'b0, 2'b00);

    // Carry ripples across three words.
    req_sub = 2'b00;
    req_a[127:0] = 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    req_b[127:0] = 128'd1;
    do_op("ripple", 2'b01, 1'b0, 128'h00000001_00000000_00000000_00000000, 1'b0, 1'b0, 2'b00);

    // 0 - 1 on requester 1: borrow out, all ones.
    req_sub = 2'b10;
    req_a[255:128] = 128'd0;
    req_b[255:128] = 128'd1;
    do_op("borrow", 2'b10, 1'b1, {128{1'b1}}, 1'b0, 1'b0, 2'b00);

    // Max positive + 1 overflows.
    req_sub = 2'b00;
    req_a[127:0] = {1'b0, {127{1'b1}}};
    req_b[127:0] = 128'd1;
    do_op("ovf", 2'b01, 1'b0, {1'b1, 127'd0}, 1'b0, 1'b1, 2'b00);

    // Backpressure: hold DONE five cycles with requester 1 waiting.
    rsp_ready = 1'b0;
    req_a[127:0] = 128'd1;
    req_b[127:0] = 128'd2;
    do_op("bp", 2'b01, 1'b0, 128'd3, 1'b0, 1'b0, 2'b10);
    held = rsp_data;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid_hold", rsp_valid, 1'b1);
      chk("bp_data_hold", rsp_data, held);
      chk("bp_ready_blocked", req_ready, 2'b00);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_release_valid", rsp_valid, 1'b0);
    chk("bp_release_ready", req_ready, 2'b10);
    req_valid = 2'b00;
    step();

    // Reset at k=2 discards the partial result immediately.
    req_a[127:0] = {4{32'h11111111}};
    req_b[127:0] = {4{32'h22222222}};
    req_valid = 2'b01;
    #1;
    chk("mid_grant", req_ready, 2'b01);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_data", rsp_data, '0);
    chk("mid_rst_id", rsp_id, 1'b0);
    chk("mid_rst_cout", rsp_cout, 1'b0);
    chk("mid_rst_ovf", rsp_ovf, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", req_ready, 2'b00);
    req_valid = 2'b00;
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    chk("no_rsp_after_rst", seen, 0);

    // last_grant is back to 1, so a tie goes to requester 0.
    req_a[255:128] = 128'd100;
    req_b[255:128] = 128'd1;
    do_op("post_rst", 2'b11, 1'b0, 128'h33333333_33333333_33333333_33333333, 1'b0, 1'b0, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
